cp0_exception_ctrl: RTL
=======================

# cp0_exception_ctrl

Coprocessor-0 controller for the MIPS core: owns the Status, Cause, EPC and BadVAddr registers and sequences exception entry, interrupt entry and RFE return. Sits beside the coprocessor decode logic and consumes its MFC0/MTC0/RFE strobes. Arbitrates the pipeline's exception reports, external interrupts, RFE and MTC0 writes, and drives the pipeline flush, stall and PC-redirect signals.

## Interface
- DATA_WIDTH, 32, register/data width
- IRQ_WIDTH, 6, external interrupt lines (map to Cause.IP[7:2])
- EXC_VECTOR, 32'h8000_0080, exception handler address

- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_copr_we  in  1  MTC0 strobe from coprocessor decode
- i_copr_re  in  1  MFC0 strobe from coprocessor decode
- i_eret  in  1  RFE strobe from coprocessor decode
- i_copr_addr  in  5  CP0 register number (rd field)
- i_wdata  in  DATA_WIDTH  MTC0 write data
- o_rdata  out  DATA_WIDTH  MFC0 read data
- i_exc_valid  in  1  synchronous exception reported by MEM stage
- i_exc_code  in  5  ExcCode of that exception
- i_mem_pc  in  DATA_WIDTH  PC of instruction in MEM
- i_mem_bd  in  1  MEM instruction is in a branch delay slot
- i_bad_vaddr  in  DATA_WIDTH  faulting address (AdEL/AdES)
- i_irq  in  IRQ_WIDTH  asynchronous external interrupts
- o_flush  out  1  flush IF..MEM
- o_stall  out  1  hold PC and pipeline registers
- o_pc_redirect  out  1  load PC from o_pc_target
- o_pc_target  out  DATA_WIDTH  redirect address

## Operation
- Register map: 8 BadVAddr (RO), 12 Status, 13 Cause, 14 EPC (RO). Other numbers read 0; writes to them are ignored.
- Status bit layout:
  - [5:0] KUo IEo KUp IEp KUc IEc stack.
  - [15:8] IM.
  - All other bits read 0.
- Cause bit layout:
  - [31] BD.
  - [15:10] IP hardware, from synchronized i_irq.
  - [9:8] IP software, MTC0-writable.
  - [6:2] ExcCode.
  - Other Cause bits read 0.
- i_irq passes through a 2-flop synchronizer before entering Cause.IP.
- int_req = Status.IEc & |(Cause.IP & Status.IM).
- o_rdata is combinational from i_copr_addr, independent of i_copr_re.
- FSM states: IDLE, ENTER, RETURN.
  - In IDLE, priority is i_exc_valid > int_req > i_eret > i_copr_we.
  - Exception or interrupt in IDLE, one-edge update:
    - EPC = i_mem_bd ? i_mem_pc-4 : i_mem_pc.
    - Cause.BD = i_mem_bd.
    - Cause.ExcCode = i_exc_code for an exception, 0 for an interrupt.
    - Status[5:0] = {Status[3:0], 2'b00}.
    - BadVAddr = i_bad_vaddr, only for codes 4 and 5.
    - Next state ENTER.
  - i_eret in IDLE: Status[5:0] = {Status[5:4], Status[5:2]}; next state RETURN.
  - i_copr_we in IDLE with no higher-priority event: write the target register. This is the only way MTC0 is accepted.
  - ENTER: o_flush=1, o_stall=1, o_pc_redirect=1, o_pc_target=EXC_VECTOR; next state IDLE.
  - RETURN: o_flush=1, o_pc_redirect=1, o_pc_target=EPC; next state IDLE.
- Events arriving in ENTER or RETURN are ignored. The pipeline is flushing, so they are reissued.
- If MTC0 and an exception occur in the same cycle, the exception wins and the write is dropped.

## Timing
- Reset:
  - All registers 0; state IDLE.
  - Outputs: o_flush, o_stall, o_pc_redirect = 0; o_pc_target = 0; o_rdata = 0 for all addresses.
- Event-to-redirect latency is 1 cycle: event sampled at edge N, redirect outputs high for exactly the cycle after edge N.
- IRQ latency: i_irq rises → Cause.IP visible after 2 edges → ENTER one edge later, if enabled.
- An MTC0 write is visible on o_rdata the cycle after the write edge.
- Reset asserted mid-sequence: outputs drop asynchronously, state returns to IDLE, no redirect is issued.

## Configuration
- COPR_TIMER_EN defined:
  - Adds Count (reg 9, RW, +1 every cycle, wraps at 2^32) and Compare (reg 11, RW).
  - Count==Compare sets a sticky timer pending bit; an MTC0 to Compare clears it.
  - The pending bit is OR'ed into Cause.IP[7].
- Not defined: regs 9 and 11 read 0, writes are ignored, and Cause.IP[7] comes from i_irq[5] only.

## Test plan
- Reset → all outputs 0; MFC0 of regs 8, 12, 13, 14 returns 0.
- i_exc_valid, code 12 (Ov), i_mem_pc=0x400, bd=1 → next cycle redirect to 0x80000080; EPC=0x3FC, Cause=0x80000030, Status[5:0]={IE stack shifted left by 2}.
- MTC0 Status=0x0401, then assert i_irq[0] → ENTER exactly 3 edges later; Cause.ExcCode=0; Status[5:0]=0x04.
- Exception and MTC0 Status in the same cycle → exception taken, Status does not take the write value; second exception during ENTER → ignored.
- RFE after entry → one-cycle redirect to EPC; Status[5:0] restored from the stack.
- COPR_TIMER_EN: Compare=10, Count=0 → Cause.IP[7] sets after 10 cycles; writing Compare clears it.

Source files
------------

// File: rtl/cp0_exception_ctrl.sv
// ---------------------------------------------------------------------------
// cp0_exception_ctrl
//   Coprocessor-0 controller. Holds Status, Cause, EPC and BadVAddr. It
//   arbitrates between pipeline exceptions, external interrupts, RFE and
//   MTC0 writes, and it drives the pipeline flush, stall and PC-redirect
//   signals.
//
//   Parameters
//     DATA_WIDTH  register/data width (32)
//     IRQ_WIDTH   external interrupt lines, mapped to Cause.IP[7:2] (6)
//     EXC_VECTOR  exception handler address
//
//   Ports
//     i_clk, i_rst_n                 clock and async active-low reset
//     i_copr_we / i_copr_re / i_eret  MTC0 / MFC0 / RFE strobes
//     i_copr_addr, i_wdata, o_rdata  CP0 register access (read is comb.)
//     i_exc_valid, i_exc_code        synchronous exception from MEM
//     i_mem_pc, i_mem_bd             PC / delay-slot flag of MEM instr.
//     i_bad_vaddr                    faulting address for AdEL/AdES
//     i_irq                          asynchronous external interrupts
//     o_flush, o_stall               pipeline control
//     o_pc_redirect, o_pc_target     PC redirect request and address
//
//   Optional feature: define COPR_TIMER_EN to add Count (reg 9) and
//   Compare (reg 11). A sticky timer-pending bit feeds Cause.IP[7].
// ---------------------------------------------------------------------------
module cp0_exception_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    IRQ_WIDTH  = 6,
  parameter logic [DATA_WIDTH-1:0] EXC_VECTOR = 32'h8000_0080
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_copr_we,
  input  logic                  i_copr_re,
  input  logic                  i_eret,
  input  logic [4:0]            i_copr_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata,
  input  logic                  i_exc_valid,
  input  logic [4:0]            i_exc_code,
  input  logic [DATA_WIDTH-1:0] i_mem_pc,
  input  logic                  i_mem_bd,
  input  logic [DATA_WIDTH-1:0] i_bad_vaddr,
  input  logic [IRQ_WIDTH-1:0]  i_irq,
  output logic                  o_flush,
  output logic                  o_stall,
  output logic                  o_pc_redirect,
  output logic [DATA_WIDTH-1:0] o_pc_target
);

  typedef enum logic [1:0] {S_IDLE, S_ENTER, S_RETURN} state_t;

  state_t state_q, state_nxt;

  logic [IRQ_WIDTH-1:0]  irq_s1_q, irq_s2_q;
  logic [7:0]            im_q;          // Status.IM
  logic [5:0]            stack_q;       // Status KUo IEo KUp IEp KUc IEc
  logic                  bd_q;          // Cause.BD
  logic [1:0]            ip_sw_q;       // Cause.IP[1:0]
  logic [4:0]            exc_code_q;    // Cause.ExcCode
  logic [DATA_WIDTH-1:0] epc_q, badvaddr_q;

  logic [IRQ_WIDTH-1:0]  ip_hw;
  logic [7:0]            cause_ip;
  logic [DATA_WIDTH-1:0] status_word, cause_word;
  logic                  int_req;
  logic                  take_exc, take_int, take_rfe, take_wr;

  // MFC0 needs no strobe (reads are side-effect free) and only some write
  // data bits land in registers.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, i_copr_re, i_wdata};

`ifdef COPR_TIMER_EN
  logic [DATA_WIDTH-1:0] count_q, compare_q;
  logic                  timer_pend_q;

  assign ip_hw = {irq_s2_q[IRQ_WIDTH-1] | timer_pend_q, irq_s2_q[IRQ_WIDTH-2:0]};

  // Count keeps running in every state. Only an accepted MTC0 reloads it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q      <= '0;
      compare_q    <= '0;
      timer_pend_q <= 1'b0;
    end else begin
      count_q <= (take_wr && i_copr_addr == 5'd9) ? i_wdata
                                                  : count_q + DATA_WIDTH'(1);
      if (take_wr && i_copr_addr == 5'd11) begin
        compare_q    <= i_wdata;
        timer_pend_q <= 1'b0;
      end else if (count_q == compare_q) begin
        timer_pend_q <= 1'b1;
      end
    end
  end
`else
  assign ip_hw = irq_s2_q;
`endif

  assign cause_ip    = {ip_hw, ip_sw_q};
  assign status_word = {{(DATA_WIDTH-16){1'b0}}, im_q, 2'b00, stack_q};
  assign cause_word  = {bd_q, {(DATA_WIDTH-17){1'b0}}, cause_ip, 1'b0,
                        exc_code_q, 2'b00};
  assign int_req     = stack_q[0] & (|(cause_ip & im_q));

  always_comb begin
    o_rdata = '0;
    case (i_copr_addr)
      5'd8:    o_rdata = badvaddr_q;
      5'd12:   o_rdata = status_word;
      5'd13:   o_rdata = cause_word;
      5'd14:   o_rdata = epc_q;
`ifdef COPR_TIMER_EN
      5'd9:    o_rdata = count_q;
      5'd11:   o_rdata = compare_q;
`endif
      default: o_rdata = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_nxt;
  end

  // NOTE: every output of this block gets a default before the case.
  // Without the defaults, a path that skips an assignment infers a latch.
  always_comb begin
    state_nxt     = state_q;
    take_exc      = 1'b0;
    take_int      = 1'b0;
    take_rfe      = 1'b0;
    take_wr       = 1'b0;
    o_flush       = 1'b0;
    o_stall       = 1'b0;
    o_pc_redirect = 1'b0;
    o_pc_target   = '0;
    case (state_q)
      S_IDLE: begin
        if (i_exc_valid) begin
          take_exc  = 1'b1;
          state_nxt = S_ENTER;
        end else if (int_req) begin
          take_int  = 1'b1;
          state_nxt = S_ENTER;
        end else if (i_eret) begin
          take_rfe  = 1'b1;
          state_nxt = S_RETURN;
        end else if (i_copr_we) begin
          take_wr   = 1'b1;
        end
      end
      // While flushing, new events are dropped. The pipeline reissues them.
      S_ENTER: begin
        o_flush       = 1'b1;
        o_stall       = 1'b1;
        o_pc_redirect = 1'b1;
        o_pc_target   = EXC_VECTOR;
        state_nxt     = S_IDLE;
      end
      S_RETURN: begin
        o_flush       = 1'b1;
        o_pc_redirect = 1'b1;
        o_pc_target   = epc_q;
        state_nxt     = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments. All registers
  // then update together from values sampled before the edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      irq_s1_q   <= '0;
      irq_s2_q   <= '0;
      im_q       <= '0;
      stack_q    <= '0;
      bd_q       <= 1'b0;
      ip_sw_q    <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else begin
      irq_s1_q <= i_irq;
      irq_s2_q <= irq_s1_q;
      if (take_exc || take_int) begin
        // The restart point of a delay-slot instruction is its branch.
        epc_q      <= i_mem_bd ? i_mem_pc - DATA_WIDTH'(4) : i_mem_pc;
        bd_q       <= i_mem_bd;
        exc_code_q <= take_exc ? i_exc_code : 5'd0;
        stack_q    <= {stack_q[3:0], 2'b00};
        if (take_exc && (i_exc_code == 5'd4 || i_exc_code == 5'd5))
          badvaddr_q <= i_bad_vaddr;
      end else if (take_rfe) begin
        stack_q <= {stack_q[5:4], stack_q[5:2]};
      end else if (take_wr) begin
        case (i_copr_addr)
          5'd12: begin
            im_q    <= i_wdata[15:8];
            stack_q <= i_wdata[5:0];
          end
          5'd13:   ip_sw_q <= i_wdata[9:8];
          default: ;
        endcase
      end
    end
  end

endmodule
